// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the 2:1 stream multiplexer.
// Contents: arbiter/lock state enum and the source-select encodings.
package stream_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic SEL_S0 = 1'b0;
    localparam logic SEL_S1 = 1'b1;

endpackage

// File: rtl/stream_mux_2x1_rr_arb2.sv
// Two-requester round-robin arbiter with optional lock to one requester.
// Ports: clk, rst_n; req[1:0] requests; lock_en/lock_sel restrict the grant
// to one requester; advance marks a granted beat accepted this cycle;
// grant[1:0] one-hot grant (combinational); last_sel = requester served last.
module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock_en,
    input  logic       lock_sel,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_sel
);

    // Grant selection: lock first, then round-robin on contention.
    always_comb begin
        grant = 2'b00;
        if (lock_en) begin
            grant = lock_sel ? {req[1], 1'b0} : {1'b0, req[0]};
        end else if (req == 2'b11) begin
            grant = (last_sel == SEL_S1) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Resets to s1 so that s0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel <= SEL_S1;
        end else if (advance) begin
            last_sel <= grant[1];
        end
    end

endmodule

// File: rtl/stream_mux_2x1.sv
// Two-input, one-output valid/ready stream multiplexer, round-robin arbitration,
// one registered output stage. m_sel reports the source of each output beat.
// Optional packet lock (no interleaving across packets): STREAM_MUX_PKT_LOCK_EN.
// Ports: clk, rst_n (async, active low); s0_*/s1_* source streams
// (valid, ready, data, last); m_* sink stream (valid, ready, data, last, sel).
module stream_mux_2x1
    import stream_mux_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_sel
);

    state_t     state;
    logic [1:0] grant;
    logic       last_sel;
    logic       space;
    logic       accept0;
    logic       accept1;
    logic       lock_en;
    logic       lock_sel;

    assign space    = !m_valid || m_ready;
    assign lock_en  = (state != IDLE);
    assign lock_sel = (state == LOCK1);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({s1_valid, s0_valid}),
        .lock_en  (lock_en),
        .lock_sel (lock_sel),
        .advance  (accept0 || accept1),
        .grant    (grant),
        .last_sel (last_sel)
    );

    // rst_n gate keeps readys low while reset is held.
    assign s0_ready = rst_n && grant[0] && space;
    assign s1_ready = rst_n && grant[1] && space;
    assign accept0  = s0_valid && s0_ready;
    assign accept1  = s1_valid && s1_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
    state_t state_nxt;

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enter lock on a non-final beat, leave on the final beat of that source.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept0 && !s0_last) begin
                    state_nxt = LOCK0;
                end else if (accept1 && !s1_last) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                if (accept0 && s0_last) begin
                    state_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (accept1 && s1_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign state = IDLE;
`endif

    // Output stage: load on accept (also covers drain+load), else clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_sel   <= SEL_S0;
        end else if (accept0) begin
            m_valid <= 1'b1;
            m_data  <= s0_data;
            m_last  <= s0_last;
            m_sel   <= SEL_S0;
        end else if (accept1) begin
            m_valid <= 1'b1;
            m_data  <= s1_data;
            m_last  <= s1_last;
            m_sel   <= SEL_S1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Self-checking bench for stream_mux_2x1: scoreboard of accepted input beats
// against output beats, plus per-scenario checks of select order and timing.
module tb_stream_mux_2x1;
    import stream_mux_pkg::*;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s0_valid, s0_ready, s0_last;
    logic [DATA_W-1:0] s0_data;
    logic              s1_valid, s1_ready, s1_last;
    logic [DATA_W-1:0] s1_data;
    logic              m_valid, m_ready, m_last, m_sel;
    logic [DATA_W-1:0] m_data;

    int assertions = 0;
    int failures   = 0;

    logic [DATA_W+1:0] sb[$];
    logic              sel_log[$];

    always #5 clk = ~clk;

    stream_mux_2x1 #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_sel    (m_sel)
    );

    // Monitor: handshakes are sampled on the falling edge, before the rising edge commits them.
    always @(negedge clk) begin
        logic [DATA_W+1:0] exp;
        if (rst_n) begin
            assertions++;
            if (s0_ready && s1_ready) begin
                failures++;
                $display("FAIL ready_onehot: s0_ready=%b s1_ready=%b, required not both high", s0_ready, s1_ready);
            end
            if (m_valid && m_ready) begin
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: output beat data=%h sel=%b with no expected beat", m_data, m_sel);
                end else begin
                    exp = sb.pop_front();
                    if ({m_sel, m_last, m_data} !== exp) begin
                        failures++;
                        $display("FAIL sb_beat: got sel=%b last=%b data=%h, required sel=%b last=%b data=%h",
                                 m_sel, m_last, m_data, exp[DATA_W+1], exp[DATA_W], exp[DATA_W-1:0]);
                    end
                end
                sel_log.push_back(m_sel);
            end
            if (s0_valid && s0_ready) sb.push_back({SEL_S0, s0_last, s0_data});
            if (s1_valid && s1_ready) sb.push_back({SEL_S1, s1_last, s1_data});
        end
    end

    task automatic idle_inputs();
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    endtask

    // Ends at posedge+1 with reset released and clean scoreboard.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        sel_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !m_valid) break;
            @(posedge clk); #1;
        end
        assertions++;
        if (sb.size() != 0 || m_valid) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d m_valid=%b, required 0 and 0", sb.size(), m_valid);
        end
    endtask

    // Drives both sources until lim0/lim1 beats are accepted; pkt0 puts last only on s0's final beat.
    task automatic run_sources(input int lim0, input int lim1, input bit pkt0,
                               input logic [DATA_W-1:0] base0, input logic [DATA_W-1:0] base1,
                               output int cycles);
        int sent0 = 0;
        int sent1 = 0;
        bit a0, a1;
        cycles = 0;
        while ((sent0 < lim0 || sent1 < lim1) && cycles < 200) begin
            s0_valid = (sent0 < lim0);
            s0_data  = base0 + DATA_W'(sent0);
            s0_last  = pkt0 ? (sent0 == lim0 - 1) : 1'b1;
            s1_valid = (sent1 < lim1);
            s1_data  = base1 + DATA_W'(sent1);
            s1_last  = 1'b1;
            @(negedge clk);
            a0 = s0_valid && s0_ready;
            a1 = s1_valid && s1_ready;
            @(posedge clk); #1;
            if (a0) sent0++;
            if (a1) sent1++;
            cycles++;
        end
        idle_inputs();
        assertions++;
        if (cycles >= 200) begin
            failures++;
            $display("FAIL source_timeout: sent0=%0d sent1=%0d, required %0d and %0d", sent0, sent1, lim0, lim1);
        end
    endtask

    task automatic check_sel_log(input string name, input logic exp_sel[$]);
        assertions++;
        if (sel_log.size() != exp_sel.size()) begin
            failures++;
            $display("FAIL %s_len: got %0d beats, required %0d", name, sel_log.size(), exp_sel.size());
        end else begin
            for (int i = 0; i < exp_sel.size(); i++) begin
                assertions++;
                if (sel_log[i] !== exp_sel[i]) begin
                    failures++;
                    $display("FAIL %s_sel[%0d]: got %b, required %b", name, i, sel_log[i], exp_sel[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h11; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h22; s1_last = 1'b1;
        sb.delete();
        sel_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        assertions++;
        if (m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: m_valid=%b s0_ready=%b s1_ready=%b, required 0 0 0", m_valid, s0_ready, s1_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        assertions++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant: s0_ready=%b s1_ready=%b, required 1 0", s0_ready, s1_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        assertions++;
        if (m_valid !== 1'b1 || m_sel !== SEL_S0 || m_data !== 8'h11) begin
            failures++;
            $display("FAIL reset_first_beat: m_valid=%b m_sel=%b m_data=%h, required 1 0 11", m_valid, m_sel, m_data);
        end
        wait_drain();
    endtask

    task automatic test_contention();
        int cycles;
        logic exp_sel[$] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        run_sources(4, 4, 1'b0, 8'hA0, 8'hB0, cycles);
        assertions++;
        if (cycles != 8) begin
            failures++;
            $display("FAIL contention_rate: got %0d cycles for 8 beats, required 8", cycles);
        end
        wait_drain();
        check_sel_log("contention", exp_sel);
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        s0_valid = 1'b1; s0_data = 8'h30; s0_last = 1'b1;
        @(posedge clk); #1;
        s0_data = 8'h31;
        s1_valid = 1'b1; s1_data = 8'h40; s1_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            assertions++;
            if (m_valid !== 1'b1 || m_data !== 8'h30 || m_sel !== SEL_S0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: m_valid=%b m_data=%h m_sel=%b s0_ready=%b s1_ready=%b, required 1 30 0 0 0",
                         m_valid, m_data, m_sel, s0_ready, s1_ready);
            end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        #1;
        assertions++;
        if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_grant: s0_ready=%b s1_ready=%b, required 0 1", s0_ready, s1_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        assertions++;
        if (m_valid !== 1'b1 || m_data !== 8'h40 || m_sel !== SEL_S1) begin
            failures++;
            $display("FAIL bp_no_bubble: m_valid=%b m_data=%h m_sel=%b, required 1 40 1", m_valid, m_data, m_sel);
        end
        wait_drain();
    endtask

    task automatic test_packet_lock();
        int cycles;
`ifdef STREAM_MUX_PKT_LOCK_EN
        logic exp_sel[$] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic exp_sel[$] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        do_reset();
        run_sources(3, 2, 1'b1, 8'h60, 8'h50, cycles);
        assertions++;
        if (cycles != 5) begin
            failures++;
            $display("FAIL lock_rate: got %0d cycles for 5 beats, required 5", cycles);
        end
        wait_drain();
        check_sel_log("lock", exp_sel);
    endtask

    task automatic test_idle_drain();
        do_reset();
        s1_valid = 1'b1; s1_data = 8'h77; s1_last = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        assertions++;
        if (m_valid !== 1'b1 || m_sel !== SEL_S1 || m_last !== 1'b0 || m_data !== 8'h77) begin
            failures++;
            $display("FAIL idle_beat: m_valid=%b m_sel=%b m_last=%b m_data=%h, required 1 1 0 77",
                     m_valid, m_sel, m_last, m_data);
        end
        @(negedge clk);
        assertions++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_drained: m_valid=%b, required 0", m_valid);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        s0_valid = 1'b1; s0_data = 8'h90; s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 8'hC0; s1_last = 1'b1;
        @(posedge clk); #1;
        s0_data = 8'h91;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear: m_valid=%b, required 0", m_valid);
        end
        s0_valid = 1'b0;
        s1_data = 8'hC1;
        @(posedge clk); #1;
        sb.delete();
        sel_log.delete();
        rst_n = 1'b1;
        #1;
        assertions++;
        if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_grant: s0_ready=%b s1_ready=%b, required 0 1", s0_ready, s1_ready);
        end
        @(posedge clk); #1;
        idle_inputs();
        assertions++;
        if (m_valid !== 1'b1 || m_sel !== SEL_S1 || m_data !== 8'hC1) begin
            failures++;
            $display("FAIL mid_reset_beat: m_valid=%b m_sel=%b m_data=%h, required 1 1 c1", m_valid, m_sel, m_data);
        end
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        m_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_contention();
        test_backpressure();
        test_packet_lock();
        test_idle_drain();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_2x1.md
# stream_mux_2x1

Two-input, one-output streaming multiplexer with round-robin arbitration and a registered output stage. It merges two valid/ready source streams onto one sink stream and reports which source each output beat came from. It is the gathering counterpart of the 1x2 demultiplexer: where that block steers one input to one of two outputs by a select, this block decides the select itself and collects two inputs onto one output.

## Interface
Parameters:
- DATA_W, 8, payload width of every data port.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- s0_valid  input  1  source 0 beat available.
- s0_ready  output  1  source 0 beat accepted this cycle when high with s0_valid.
- s0_data  input  DATA_W  source 0 payload.
- s0_last  input  1  source 0 end-of-packet marker.
- s1_valid, s1_ready, s1_data, s1_last: same widths and meaning for source 1.
- m_valid  output  1  output beat available.
- m_ready  input  1  sink accepts output beat.
- m_data  output  DATA_W  output payload.
- m_last  output  1  output end-of-packet marker.
- m_sel  output  1  source of the current output beat: 0 = s0, 1 = s1.

## Operation
- Transfer on any port happens on a rising clk edge where valid and ready are both high.
- Output register: one stage holding m_valid, m_data, m_last and m_sel. It has space when m_valid=0 or m_ready=1.
- Grant rules:
  - If only one source is valid, grant it.
  - If both are valid, grant the source not served last. The `last_sel` flop updates on every accepted input beat.
- s0_ready = grant0 AND space, and likewise for s1. At most one sXready is high per cycle. sXready is combinational from s0_valid, s1_valid, m_ready and the state.
- An accepted beat loads the output register with that source's data and last flag, and sets m_sel to that source.
- If the output beat drains and no input is accepted in the same cycle, m_valid clears.
- Payload, last and sel pass through unmodified. There is no width conversion.
- State machine (lock; see Configuration):
  - IDLE: arbitrate normally.
  - LOCK0 / LOCK1: only the locked source may be granted; the other source's ready is held low even if it is valid.
  - Transitions:
    - IDLE→LOCKx when a beat from source x is accepted with last=0.
    - LOCKx→IDLE when a beat from source x is accepted with last=1.
    - A beat accepted with last=1 from IDLE stays in IDLE.
- Boundary behaviour:
  - Both sources idle: no grant, readys low, and the output drains normally.
  - m_ready held low with output full: both readys low and the output register holds stable.
  - Drain and load in the same cycle: the new beat replaces the old one with no bubble.
  - Reset asserted mid-packet: all state is cleared immediately. A partially sent packet is abandoned and it is not an error.

## Timing
- Latency: input accept to m_valid high is 1 cycle.
- Throughput: 1 beat per cycle with m_ready held high, including alternating sources.
- Reset values (asynchronous):
  - Outputs: m_valid=0, m_data=0, m_last=0, m_sel=0, s0_ready=0, s1_ready=0.
  - Internal: state=IDLE, last_sel=1, so s0 wins the first contention.
- No combinational path from m_ready to m_valid, m_data or m_sel. A path from m_ready to sXready is permitted.
- Once m_valid is high, m_data, m_last and m_sel are held until the beat is accepted.

## Configuration
- STREAM_MUX_PKT_LOCK_EN defined:
  - The LOCK0/LOCK1 states are built.
  - Packets never interleave on the output; the arbiter switches only after a beat with last=1.
- Not defined:
  - The state is constant IDLE and arbitration happens on every beat.
  - The last flag is still carried through unchanged.

## Structure
- Package stream_mux_pkg holds:
  - The state enum (IDLE, LOCK0, LOCK1).
  - The select constants SEL_S0=1'b0 and SEL_S1=1'b1.
- Sub-module rr_arb2 is the two-requester round-robin arbiter.
  - Inputs: req[1:0], lock_en, lock_sel, advance.
  - Outputs: grant[1:0], plus the last_sel flop.
- The top level holds the output register, the FSM and the ready logic.

## Test plan
- Reset: hold rst_n=0 with both sources valid. Required: m_valid=0, s0_ready=0, s1_ready=0. Release reset with m_ready=1. Required: first beat accepted from s0, m_valid=1 on the next cycle with m_sel=0.
- Contention: both sources continuously valid, single-beat packets, s0_data=0xA0.., s1_data=0xB0.., m_ready=1. Required: m_sel sequence 0,1,0,1, one beat per cycle, data in order per source.
- Backpressure: output full, m_ready=0 for 5 cycles. Required: m_data and m_sel stable, both readys low. Then m_ready=1. Required: the held beat drains and the next beat loads in the same cycle.
- Packet lock (macro defined): s0 sends a 3-beat packet with last on beat 3 while s1 is valid throughout. Required: three s0 beats in a row, then s1 granted. With the macro undefined, required: interleaved 0,1,0,1,0.
- Idle drain: a single s1 beat with s0 idle. Required: m_sel=1, m_last equals the input last, and m_valid=0 the cycle after acceptance.
- Reset mid-packet: assert rst_n=0 while in LOCK0. Required: m_valid=0 immediately. After release, s1 is granted if only s1 is valid.
